// File: rtl/jtpopeye_prom_loader_pkg.sv
// Shared constants and types for the Popeye colour-PROM loader.
package jtpopeye_prom_loader_pkg;

  // Segment layout of the colour-PROM image inside the ROM space
  localparam int unsigned SEG_3A_BASE = 0;
  localparam int unsigned SEG_3A_SIZE = 32;
  localparam int unsigned SEG_4A_BASE = 32;
  localparam int unsigned SEG_4A_SIZE = 32;
  localparam int unsigned SEG_5A_BASE = 64;
  localparam int unsigned SEG_5A_SIZE = 256;
  localparam int unsigned SEG_5B_BASE = 320;
  localparam int unsigned SEG_5B_SIZE = 256;
  localparam int unsigned IMG_LEN     = 576;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WRITE,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    SEG_3A,
    SEG_4A,
    SEG_5A,
    SEG_5B
  } seg_t;

  typedef struct packed {
    seg_t       seg;
    logic [7:0] addr;
  } seg_dec_t;

  // Map an image index to its target PROM and segment-relative address
  function automatic seg_dec_t seg_decode(input logic [9:0] n);
    seg_dec_t d;
    if (n < 10'(SEG_3A_BASE + SEG_3A_SIZE)) begin
      d.seg  = SEG_3A;
      d.addr = 8'(n - 10'(SEG_3A_BASE));
    end else if (n < 10'(SEG_4A_BASE + SEG_4A_SIZE)) begin
      d.seg  = SEG_4A;
      d.addr = 8'(n - 10'(SEG_4A_BASE));
    end else if (n < 10'(SEG_5A_BASE + SEG_5A_SIZE)) begin
      d.seg  = SEG_5A;
      d.addr = 8'(n - 10'(SEG_5A_BASE));
    end else begin
      d.seg  = SEG_5B;
      d.addr = 8'(n - 10'(SEG_5B_BASE));
    end
    return d;
  endfunction

endpackage

// File: rtl/jtpopeye_prom_loader.sv
// Copies the 576-byte colour-PROM image from ROM into the four colour
// PROMs (3a, 4a, 5a, 5b), one byte per REQ/WRITE handshake.
module jtpopeye_prom_loader
  import jtpopeye_prom_loader_pkg::*;
#(
  parameter logic [9:0] BASE = 10'h000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [9:0] rom_addr,
  output logic       rom_req,
  input  logic       rom_ok,
  input  logic [7:0] rom_data,
  output logic [7:0] prog_addr,
  output logic [7:0] prom_din,
  output logic       prom_3a_we,
  output logic       prom_4a_we,
  output logic       prom_5a_we,
  output logic       prom_5b_we,
  output logic       busy,
  output logic       done
);

  state_t     state, state_nx;
  logic [9:0] n;
  seg_t       seg_q;
  seg_dec_t   dec;
  logic       last;

  // Segment decode of the current image index
  always_comb begin
    dec  = seg_decode(n);
    last = (n == 10'(IMG_LEN - 1));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start)  state_nx = ST_REQ;
      ST_REQ:   if (rom_ok) state_nx = ST_WRITE;
      ST_WRITE: state_nx = last ? ST_DONE : ST_REQ;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Datapath: index, ROM address and latched write data/address.
  // rom_addr is registered (not BASE+n combinationally) so it reads 0 in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n         <= '0;
      rom_addr  <= '0;
      prog_addr <= '0;
      prom_din  <= '0;
      seg_q     <= SEG_3A;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            n        <= '0;
            rom_addr <= BASE;
          end
        end
        ST_REQ: begin
          if (rom_ok) begin
            prom_din  <= rom_data;
            prog_addr <= dec.addr;
            seg_q     <= dec.seg;
          end
        end
        ST_WRITE: begin
          if (!last) begin
            n        <= n + 10'd1;
            rom_addr <= BASE + n + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from state and latched segment
  always_comb begin
    rom_req    = (state == ST_REQ);
    busy       = (state == ST_REQ) || (state == ST_WRITE);
    done       = (state == ST_DONE);
    prom_3a_we = 1'b0;
    prom_4a_we = 1'b0;
    prom_5a_we = 1'b0;
    prom_5b_we = 1'b0;
    if (state == ST_WRITE) begin
      case (seg_q)
        SEG_3A:  prom_3a_we = 1'b1;
        SEG_4A:  prom_4a_we = 1'b1;
        SEG_5A:  prom_5a_we = 1'b1;
        default: prom_5b_we = 1'b1;
      endcase
    end
  end

endmodule
